// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory/IO bus between a CPU and a DMA requester.
// Moore FSM CPU -> STALL -> DMA -> COOL -> CPU. The CPU owns the bus by default.
// A DMA request stalls the CPU for one cycle, then grants the bus to DMA.
// After the grant ends, COOL gives the CPU guaranteed cycles before DMA can win again.
//
// Optional feature macro: BUS_ARB_FAIR_EN
//   defined   : a DMA grant is limited to MAX_BURST cycles, and COOL lasts CPU_SLOTS cycles.
//   undefined : a DMA grant lasts as long as dma_req stays high, and COOL lasts one cycle.
`timescale 1ns/1ps

module bus_arbiter #(
  parameter int MAX_BURST = 16,  // max consecutive DMA cycles per grant (1..255)
  parameter int CPU_SLOTS = 2    // min CPU cycles after a grant ends (1..255)
) (
  input  logic        clk,
  input  logic        reset,      // asynchronous, active low
  // CPU side
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  // DMA side
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic [15:0] dma_ab,
  input  logic [7:0]  dma_do,
  input  logic        dma_we,
  // shared bus
  output logic [15:0] bus_ab,
  output logic [7:0]  bus_do,
  output logic        bus_we,
  // debug
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_STALL = 2'd1,
    ST_DMA   = 2'd2,
    ST_COOL  = 2'd3
  } arb_state_t;

`ifdef BUS_ARB_FAIR_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  // Without the fairness feature the burst counter simply saturates at its
  // 8-bit ceiling and COOL is a single cycle.
  localparam int BURST_CAP = FAIR_EN ? MAX_BURST : 255;
  localparam int SLOT_CAP  = FAIR_EN ? CPU_SLOTS : 1;
  localparam logic [7:0] BURST_LIMIT = BURST_CAP[7:0];
  localparam logic [7:0] SLOT_LIMIT  = SLOT_CAP[7:0];

  arb_state_t state;
  arb_state_t state_next;
  logic [7:0] burst_cnt;
  logic [7:0] burst_cnt_next;
  logic [7:0] slot_cnt;
  logic [7:0] slot_cnt_next;

  logic [7:0] burst_inc;
  logic [7:0] slot_inc;
  logic       burst_done;
  logic       slot_done;

  // Saturating increments: counters hold at their limit and never wrap.
  always_comb begin
    burst_inc = (burst_cnt >= BURST_LIMIT) ? burst_cnt : burst_cnt + 8'd1;
    slot_inc  = (slot_cnt  >= SLOT_LIMIT)  ? slot_cnt  : slot_cnt  + 8'd1;
  end

`ifdef BUS_ARB_FAIR_EN
  // The current DMA cycle is the last one allowed in this grant.
  assign burst_done = (burst_inc >= BURST_LIMIT);
`else
  // No burst limit: DMA keeps the bus for as long as it requests it.
  assign burst_done = 1'b0;
`endif

  // The current COOL cycle completes the guaranteed CPU slots.
  assign slot_done = (slot_inc >= SLOT_LIMIT);

  // State and counter registers; reset forces CPU ownership at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_CPU;
      burst_cnt <= 8'd0;
      slot_cnt  <= 8'd0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_cnt_next;
      slot_cnt  <= slot_cnt_next;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_next     = state;
    burst_cnt_next = burst_cnt;
    slot_cnt_next  = slot_cnt;
    case (state)
      ST_CPU: begin
        if (dma_req) begin
          state_next = ST_STALL;
        end
      end
      ST_STALL: begin
        // One stall cycle lets the CPU's current access drain. DMA follows
        // even if the request has already been withdrawn.
        state_next     = ST_DMA;
        burst_cnt_next = 8'd0;
      end
      ST_DMA: begin
        burst_cnt_next = burst_inc;
        if (!dma_req || burst_done) begin
          state_next    = ST_COOL;
          slot_cnt_next = 8'd0;
        end
      end
      ST_COOL: begin
        // dma_req is deliberately ignored here so that the CPU gets its slots.
        slot_cnt_next = slot_inc;
        if (slot_done) begin
          state_next = ST_CPU;
        end
      end
      default: begin
        state_next = ST_CPU;
      end
    endcase
  end

  // Moore outputs and bus mux; handshake lines depend on the state only.
  always_comb begin
    cpu_rdy   = 1'b1;
    dma_gnt   = 1'b0;
    bus_ab    = cpu_ab;
    bus_do    = cpu_do;
    bus_we    = cpu_we;
    arb_state = state;
    case (state)
      ST_STALL: begin
        cpu_rdy = 1'b0;
        bus_we  = 1'b0;  // a stalled CPU must not commit a write
      end
      ST_DMA: begin
        cpu_rdy = 1'b0;
        dma_gnt = 1'b1;
        bus_ab  = dma_ab;
        bus_do  = dma_do;
        bus_we  = dma_we;
      end
      default: begin
        cpu_rdy = 1'b1;
      end
    endcase
  end

endmodule
